// File: rtl/a2d_spi_pots.sv
// Behavioural SPI slave modelling an 8-channel 12-bit A2D with six pot inputs.
// Optional macro A2D_CMD_CHECK_EN: malformed command frames convert to 12'hBAD.
module a2d_spi_pots #(
    parameter logic [2:0] CH_LP  = 3'd1,
    parameter logic [2:0] CH_B1  = 3'd0,
    parameter logic [2:0] CH_B2  = 3'd4,
    parameter logic [2:0] CH_B3  = 3'd2,
    parameter logic [2:0] CH_HP  = 3'd3,
    parameter logic [2:0] CH_VOL = 3'd7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [11:0] LP,
    input  logic [11:0] B1,
    input  logic [11:0] B2,
    input  logic [11:0] B3,
    input  logic [11:0] HP,
    input  logic [11:0] VOL
);

    localparam logic [4:0] FRAME_BITS = 5'd16;

    // Two-flop synchronisers plus one delayed copy for edge detection.
    logic ss_meta_q,   ss_meta_d,   ss_sync_q,   ss_sync_d,   ss_prev_q,   ss_prev_d;
    logic sclk_meta_q, sclk_meta_d, sclk_sync_q, sclk_sync_d, sclk_prev_q, sclk_prev_d;
    logic mosi_meta_q, mosi_meta_d, mosi_sync_q, mosi_sync_d;

    logic [15:0] rx_q, rx_d;
    logic [15:0] tx_q, tx_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  ch_q, ch_d;
    logic [11:0] result_q, result_d;
    logic        conv_pend_q, conv_pend_d;
    logic        bad_pend_q, bad_pend_d;

    logic        ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic        cmd_invalid;
    logic [11:0] pot_val;

    assign ss_fall   = ss_prev_q & ~ss_sync_q;
    assign ss_rise   = ~ss_prev_q & ss_sync_q;
    assign sclk_rise = ~sclk_prev_q & sclk_sync_q;
    assign sclk_fall = sclk_prev_q & ~sclk_sync_q;

`ifdef A2D_CMD_CHECK_EN
    assign cmd_invalid = (rx_q[15:14] != 2'b00) || (rx_q[10:0] != 11'h000);
`else
    logic cmd_bits_unused;
    assign cmd_invalid     = 1'b0;
    assign cmd_bits_unused = rx_q[15];
`endif

    // Nothing is driven once the frame has delivered all 16 bits.
    assign MISO = ~ss_sync_q & (bit_cnt_q != FRAME_BITS) & tx_q[15];

    always_comb begin
        pot_val = 12'h000;
        if (ch_q == CH_VOL) pot_val = VOL;
        if (ch_q == CH_HP)  pot_val = HP;
        if (ch_q == CH_B3)  pot_val = B3;
        if (ch_q == CH_B2)  pot_val = B2;
        if (ch_q == CH_B1)  pot_val = B1;
        if (ch_q == CH_LP)  pot_val = LP;
    end

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        ss_meta_d   = SS_n;
        ss_sync_d   = ss_meta_q;
        ss_prev_d   = ss_sync_q;
        sclk_meta_d = SCLK;
        sclk_sync_d = sclk_meta_q;
        sclk_prev_d = sclk_sync_q;
        mosi_meta_d = MOSI;
        mosi_sync_d = mosi_meta_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        bit_cnt_d   = bit_cnt_q;
        ch_d        = ch_q;
        result_d    = result_q;
        conv_pend_d = 1'b0;
        bad_pend_d  = 1'b0;

        if (ss_fall) begin
            bit_cnt_d = 5'd0;
            rx_d      = 16'h0000;
            tx_d      = {4'h0, result_q};
        end else if (!ss_sync_q) begin
            if (sclk_rise && bit_cnt_q != FRAME_BITS) begin
                rx_d      = {rx_q[14:0], mosi_sync_q};
                bit_cnt_d = bit_cnt_q + 5'd1;
            end
            if (sclk_fall) begin
                tx_d = {tx_q[14:0], 1'b0};
            end
        end

        // Channel is captured at frame end; the pot is sampled one clk later.
        if (ss_rise && bit_cnt_q == FRAME_BITS) begin
            if (cmd_invalid) begin
                bad_pend_d = 1'b1;
            end else begin
                ch_d        = rx_q[13:11];
                conv_pend_d = 1'b1;
            end
        end

        if (conv_pend_q) result_d = pot_val;
        if (bad_pend_q)  result_d = 12'hBAD;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_meta_q   <= 1'b1;
            ss_sync_q   <= 1'b1;
            ss_prev_q   <= 1'b1;
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            rx_q        <= 16'h0000;
            tx_q        <= 16'h0000;
            bit_cnt_q   <= 5'd0;
            ch_q        <= 3'd0;
            result_q    <= 12'h000;
            conv_pend_q <= 1'b0;
            bad_pend_q  <= 1'b0;
        end else begin
            ss_meta_q   <= ss_meta_d;
            ss_sync_q   <= ss_sync_d;
            ss_prev_q   <= ss_prev_d;
            sclk_meta_q <= sclk_meta_d;
            sclk_sync_q <= sclk_sync_d;
            sclk_prev_q <= sclk_prev_d;
            mosi_meta_q <= mosi_meta_d;
            mosi_sync_q <= mosi_sync_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            bit_cnt_q   <= bit_cnt_d;
            ch_q        <= ch_d;
            result_q    <= result_d;
            conv_pend_q <= conv_pend_d;
            bad_pend_q  <= bad_pend_d;
        end
    end

endmodule

// File: tb/tb_a2d_spi_pots.sv
// Bench for a2d_spi_pots: directed test-plan frames plus randomized frames vs a frame-level model.
module tb_a2d_spi_pots;

    localparam logic [2:0] CH_LP  = 3'd1;
    localparam logic [2:0] CH_B1  = 3'd0;
    localparam logic [2:0] CH_B2  = 3'd4;
    localparam logic [2:0] CH_B3  = 3'd2;
    localparam logic [2:0] CH_HP  = 3'd3;
    localparam logic [2:0] CH_VOL = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ss_n = 1'b1;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        miso;
    logic [11:0] lp = '0, b1 = '0, b2 = '0, b3 = '0, hp = '0, vol = '0;

    int checks   = 0;
    int failures = 0;

    // Frame-level model: the word returned by a frame is the conversion of the last complete frame.
    logic [11:0] res_m = 12'h000;

    always #5 clk = ~clk;

    a2d_spi_pots dut (
        .clk  (clk),
        .rst  (rst),
        .SS_n (ss_n),
        .SCLK (sclk),
        .MOSI (mosi),
        .MISO (miso),
        .LP   (lp),
        .B1   (b1),
        .B2   (b2),
        .B3   (b3),
        .HP   (hp),
        .VOL  (vol)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] pot_of(input logic [2:0] ch);
        logic [11:0] by_ch [8];
        for (int i = 0; i < 8; i++) by_ch[i] = 12'h000;
        by_ch[CH_VOL] = vol;
        by_ch[CH_HP]  = hp;
        by_ch[CH_B3]  = b3;
        by_ch[CH_B2]  = b2;
        by_ch[CH_B1]  = b1;
        by_ch[CH_LP]  = lp;
        return by_ch[ch];
    endfunction

    function automatic bit cmd_ok(input logic [15:0] cmd);
`ifdef A2D_CMD_CHECK_EN
        return (cmd[15:14] == 2'b00) && (cmd[10:0] == 11'h000);
`else
        return 1'b1;
`endif
    endfunction

    task automatic randomize_pots();
        lp  = 12'($urandom);
        b1  = 12'($urandom);
        b2  = 12'($urandom);
        b3  = 12'($urandom);
        hp  = 12'($urandom);
        vol = 12'($urandom);
    endtask

    // One SPI mode-0 frame of nbits rises; checks the returned bits against the model.
    task automatic xfer(input logic [15:0] cmd, input int nbits, input bit mid_change,
                        input string tag, output logic [15:0] word);
        logic [15:0] exp_word;
        logic [31:0] cap;
        exp_word = {4'h0, res_m};
        cap      = 32'h0;
        ss_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < 16) ? cmd[15-i] : 1'($urandom);
            repeat (6) @(negedge clk);
            cap  = {cap[30:0], miso};
            sclk = 1'b1;
            if (mid_change && i == 8) randomize_pots();
            repeat (6) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (6) @(negedge clk);
        ss_n = 1'b1;
        mosi = 1'b0;
        if (nbits >= 16) begin
            word = 16'(cap >> (nbits - 16));
            check(tag, {16'h0, word}, {16'h0, exp_word});
            if (nbits > 16)
                check({tag, "_tail"}, cap & ((32'h1 << (nbits - 16)) - 32'h1), 32'h0);
            res_m = cmd_ok(cmd) ? pot_of(cmd[13:11]) : 12'hBAD;
        end else begin
            word = 16'(cap);
            check({tag, "_part"}, cap, {16'h0, exp_word >> (16 - nbits)});
        end
        repeat (10) @(negedge clk);
    endtask

    function automatic logic [15:0] rd_cmd(input logic [2:0] ch);
        return {2'b00, ch, 11'h000};
    endfunction

    logic [15:0] w;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_miso", {31'h0, miso}, 32'h0);
        check("rst_miso_x", {31'h0, $isunknown(miso)}, 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_miso", {31'h0, miso}, 32'h0);

        lp = 12'hFFF;
        xfer(rd_cmd(3'd1), 16, 1'b0, "first_frame", w);
        check("first_word", {16'h0, w}, 32'h0000);
        xfer(16'h0000, 16, 1'b0, "lp_read", w);
        check("lp_word", {16'h0, w}, 32'h0FFF);

        vol = 12'hA5C;
        b2  = 12'h123;
        xfer(rd_cmd(3'd7), 16, 1'b0, "cmd_vol", w);
        xfer(rd_cmd(3'd4), 16, 1'b0, "vol_read", w);
        check("vol_word", {16'h0, w}, 32'h0A5C);
        xfer(16'h0000, 16, 1'b0, "b2_read", w);
        check("b2_word", {16'h0, w}, 32'h0123);

        xfer(rd_cmd(3'd5), 16, 1'b0, "cmd_unused", w);
        xfer(16'h0000, 16, 1'b0, "unused_read", w);
        check("unused_word", {16'h0, w}, 32'h0000);

        b1 = 12'h800;
        xfer(rd_cmd(3'd0), 16, 1'b0, "cmd_b1", w);
        xfer(rd_cmd(3'd6), 8, 1'b0, "abort", w);
        xfer(16'h0000, 16, 1'b0, "after_abort", w);
        check("b1_word", {16'h0, w}, 32'h0800);

        xfer(16'h4800, 16, 1'b0, "cmd_bad", w);
        xfer(16'h0000, 16, 1'b0, "bad_read", w);
`ifdef A2D_CMD_CHECK_EN
        check("bad_word", {16'h0, w}, 32'h0BAD);
`else
        check("bad_word", {16'h0, w}, {20'h0, lp});
`endif

        hp = 12'h3C7;
        xfer(rd_cmd(3'd3), 20, 1'b0, "long_frame", w);
        xfer(16'h0000, 16, 1'b0, "long_read", w);
        check("hp_word", {16'h0, w}, {20'h0, hp});

        // Reset in the middle of a frame.
        ss_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            mosi = 1'b1;
            repeat (6) @(negedge clk);
            sclk = 1'b1;
            repeat (6) @(negedge clk);
            sclk = 1'b0;
        end
        rst  = 1'b1;
        ss_n = 1'b1;
        mosi = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_miso", {31'h0, miso}, 32'h0);
        rst   = 1'b0;
        res_m = 12'h000;
        repeat (6) @(negedge clk);
        xfer(rd_cmd(3'd2), 16, 1'b0, "post_rst", w);
        check("post_rst_word", {16'h0, w}, 32'h0000);
        xfer(16'h0000, 16, 1'b0, "post_rst_read", w);

        for (int n = 0; n < 30; n++) begin
            logic [15:0] cmd;
            int          nb;
            int          sel;
            randomize_pots();
            cmd = ($urandom_range(3) == 0) ? 16'($urandom) : rd_cmd(3'($urandom));
            sel = $urandom_range(19);
            if (sel < 3)      nb = $urandom_range(15, 1);
            else if (sel < 5) nb = $urandom_range(20, 17);
            else              nb = 16;
            xfer(cmd, nb, 1'($urandom), $sformatf("rnd%0d", n), w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
